// File: rtl/byte_unstriping_pkg.sv
// Shared constants for the byte striping TX/RX pair.
//   LANES              : number of physical lanes
//   DEFAULT_DATA_WIDTH : default byte width per lane
//   LANE_IDX_W         : width of a lane index
//   LANE_START         : first lane in the reassembly order
package byte_unstriping_pkg;

  localparam int LANES              = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int LANE_IDX_W         = 2;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  localparam lane_idx_t LANE_START = 2'd0;

  // Next lane in round-robin order; the 2-bit index wraps 3 -> 0 naturally.
  function automatic lane_idx_t next_lane(input lane_idx_t cur);
    return cur + 2'd1;
  endfunction

endpackage

// File: rtl/byte_unstriping_lane_fifo.sv
// lane_fifo: per-lane byte FIFO for the unstriper.
//   CLK   : clock, rising edge
//   RESET : synchronous active-low reset (pointers/count only, not storage)
//   push  : write request; ignored while full
//   din   : write data
//   pop   : read request; ignored while empty
//   dout  : head entry (meaningful when !empty)
//   full  : count == FIFO_DEPTH, from registered state
//   empty : count == 0, from registered state
module lane_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // Byte storage; deliberately has no reset.
  logic [DATA_WIDTH-1:0] storage [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == CNT_ZERO);
  assign dout  = storage[rd_ptr_q];

  // Next-state for pointers and occupancy. full comes from the registered
  // count, so a full FIFO refuses a write even in the cycle it is popped.
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; writes presented during reset are discarded.
  always_ff @(posedge CLK) begin
    if (RESET && push_ok) begin
      storage[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/byte_unstriping.sv
// byte_unstriping: merges four independently arriving lane byte streams
// back into one stream in strict lane order 0,1,2,3,0,...
//   CLK        : clock, rising edge
//   RESET      : synchronous active-low reset
//   data0..3   : lane bytes, qualified by valid_in[i]
//   valid_in   : per-lane write strobe
//   ready_in   : per-lane "FIFO not full"
//   ready_out  : downstream accepts DATA
//   DATA       : reassembled byte (0 when VALID_OUT=0)
//   VALID_OUT  : head of the current lane's FIFO is available
//   lane_ptr   : lane whose byte is next in order
//   overflow   : sticky per-lane "byte dropped while full"
module byte_unstriping
  import byte_unstriping_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic [DATA_WIDTH-1:0] data2,
  input  logic [DATA_WIDTH-1:0] data3,
  input  logic [LANES-1:0]      valid_in,
  output logic [LANES-1:0]      ready_in,
  input  logic                  ready_out,
  output logic [DATA_WIDTH-1:0] DATA,
  output logic                  VALID_OUT,
  output logic [1:0]            lane_ptr,
  output logic [LANES-1:0]      overflow
);

  logic [DATA_WIDTH-1:0] lane_din  [LANES];
  logic [DATA_WIDTH-1:0] lane_dout [LANES];
  logic [LANES-1:0]      lane_pop;
  logic [LANES-1:0]      lane_full;
  logic [LANES-1:0]      lane_empty;

  lane_idx_t        lane_ptr_q, lane_ptr_d;
  logic [LANES-1:0] overflow_q, overflow_d;
  logic             valid_s;
  logic             pop_fire_s;

  assign lane_din[0] = data0;
  assign lane_din[1] = data1;
  assign lane_din[2] = data2;
  assign lane_din[3] = data3;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .CLK   (CLK),
      .RESET (RESET),
      .push  (valid_in[g]),
      .din   (lane_din[g]),
      .pop   (lane_pop[g]),
      .dout  (lane_dout[g]),
      .full  (lane_full[g]),
      .empty (lane_empty[g])
    );
  end

  // Output mux and handshake. Only the lane under lane_ptr may be popped, so
  // data sitting in other lanes never overtakes a missing byte.
  always_comb begin
    valid_s              = ~lane_empty[lane_ptr_q];
    pop_fire_s           = valid_s & ready_out;
    lane_pop             = {LANES{1'b0}};
    lane_pop[lane_ptr_q] = pop_fire_s;
    lane_ptr_d           = pop_fire_s ? next_lane(lane_ptr_q) : lane_ptr_q;
    overflow_d           = overflow_q | (valid_in & lane_full);
    DATA                 = valid_s ? lane_dout[lane_ptr_q] : {DATA_WIDTH{1'b0}};
  end

  assign VALID_OUT = valid_s;
  assign ready_in  = ~lane_full;
  assign lane_ptr  = lane_ptr_q;
  assign overflow  = overflow_q;

  // Lane order pointer and sticky overflow flags.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      lane_ptr_q <= LANE_START;
      overflow_q <= {LANES{1'b0}};
    end else begin
      lane_ptr_q <= lane_ptr_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
